// File: rtl/l0_seq_ctrl.sv
// l0_seq_ctrl: sequences one activation tile from SRAM into the 8-row L0
// buffer, then holds the L0 read request for exactly len cycles so every row
// FIFO pops the whole tile into the array. All outputs are registered.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; latches base_addr/len
// FILL   | issuing SRAM reads (one per cycle while l0_ready), writes follow
// WAITWR | all reads issued; waiting for the last write into L0
// DRAIN  | l0_rd held high for exactly len cycles
// FLUSH  | l0_rd low for ROW cycles while the L0 read-enable ramp empties
// DONE   | one-cycle done pulse, then back to IDLE
module l0_seq_ctrl #(
  parameter int ROW    = 8,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 7,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  input  logic              l0_ready,
  input  logic              l0_full,
  output logic              ovf_err
);

  localparam int FL_W = $clog2(ROW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WAITWR, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    iss_cnt_q, iss_cnt_d;
  logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [FL_W-1:0]     fl_cnt_q, fl_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cen_q, cen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                ovf_q, ovf_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    cen_d     = 1'b1;
    rd_d      = 1'b0;
    // SRAM data returns one cycle after a cen-low cycle; the write strobe is
    // that read's valid bit, so in-flight reads land even if l0_ready drops.
    wr_d      = ~cen_q;
    wr_cnt_d  = wr_cnt_q + LEN_W'(wr_q);
    ovf_d     = ovf_q | (wr_q & l0_full);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            base_d    = base_addr;
            // An over-long tile would overflow the row FIFOs; clamp it.
            len_d     = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
            iss_cnt_d = '0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            state_d   = S_FILL;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FILL: begin
        if (l0_ready && (iss_cnt_q < len_q)) begin
          cen_d     = 1'b0;
          addr_d    = base_q + ADDR_W'(iss_cnt_q);
          iss_cnt_d = iss_cnt_q + 1'b1;
          if (iss_cnt_d == len_q) state_d = S_WAITWR;
        end
      end
      S_WAITWR: begin
        // Start reading the cycle right after the last write lands.
        if (wr_cnt_d == len_q) begin
          rd_d    = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_d < len_q) begin
          rd_d = 1'b1;
        end else begin
          fl_cnt_d = FL_W'(ROW - 1);
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fl_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          fl_cnt_d = fl_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      iss_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cen_q     <= 1'b1;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      iss_cnt_q <= iss_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cen_q     <= cen_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_cen  = cen_q;
  assign sram_wen  = 1'b1;
  assign sram_addr = addr_q;
  assign l0_wr     = wr_q;
  assign l0_rd     = rd_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_l0_seq_ctrl.sv
// Testbench for l0_seq_ctrl: table-driven tiles, random tiles with random
// l0_ready, and hand-written reset / overflow sequences. Expected behaviour
// comes from a tile-level model: the first len ready-high FILL cycles issue
// reads, writes follow by one cycle, reads follow the last write for len
// cycles, then ROW flush cycles before done.
module tb_l0_seq_ctrl;
  localparam int ROW    = 8;
  localparam int ADDR_W = 11;
  localparam int LEN_W  = 7;
  localparam int DEPTH  = 64;
  localparam int LIM    = 1000;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done, sram_cen, sram_wen, l0_wr, l0_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic              l0_ready, l0_full, ovf_err;

  l0_seq_ctrl #(.ROW(ROW), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_ready(l0_ready),
    .l0_full(l0_full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cen"},  int'(sram_cen), 1);
    chk({tag, "_wen"},  int'(sram_wen), 1);
    chk({tag, "_addr"}, int'(sram_addr), 0);
    chk({tag, "_wr"},   int'(l0_wr), 0);
    chk({tag, "_rd"},   int'(l0_rd), 0);
    chk({tag, "_ovf"},  int'(ovf_err), 0);
  endtask

  typedef struct {
    int base;
    int ln;
    int mode;      // 0: ready always high, 1: ready low in [s0, s0+sl)
    int s0;
    int sl;
    int spur;      // cycle of an extra start pulse while busy (0: none)
    int exp_done;  // cycle of done after the start cycle
  } vec_t;

  vec_t tbl[6];

  int  cen_cyc[$], addr_tr[$], wr_cyc[$], rd_cyc[$], done_cyc[$];
  bit  rdy_h[LIM];
  bit  busy_h[LIM];

  // Drive one tile (start in cycle 0), record the output trace, then compare
  // against the tile-level model.
  task automatic run_tile(input int base, input int ln, input int mode,
                          input int s0, input int sl, input int spur,
                          input int exp_tab, input string tag);
    int iss_c[$];
    int last_k, kk, exp_done, busy_bad, wen_bad, ovf_seen;
    cen_cyc.delete(); addr_tr.delete(); wr_cyc.delete();
    rd_cyc.delete(); done_cyc.delete();
    busy_bad = 0; wen_bad = 0; ovf_seen = 0; last_k = 0;
    for (int i = 0; i < LIM; i++) begin rdy_h[i] = 1'b0; busy_h[i] = 1'b0; end

    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(base); len = LEN_W'(ln); l0_ready = 1'b1;
    for (int k = 1; k < LIM; k++) begin
      @(posedge clk); #1;
      last_k = k;
      if (!sram_cen) begin cen_cyc.push_back(k); addr_tr.push_back(int'(sram_addr)); end
      if (l0_wr) wr_cyc.push_back(k);
      if (l0_rd) rd_cyc.push_back(k);
      if (done)  done_cyc.push_back(k);
      busy_h[k] = busy;
      if (!sram_wen) wen_bad++;
      if (ovf_err) ovf_seen++;
      // Scramble base/len every cycle: the DUT must use its latched copies.
      start     = (spur != 0 && k == spur);
      base_addr = ADDR_W'($urandom);
      len       = LEN_W'($urandom_range(1, DEPTH));
      if (mode == 0)      l0_ready = 1'b1;
      else if (mode == 1) l0_ready = !(k >= s0 && k < s0 + sl);
      else                l0_ready = ($urandom_range(0, 3) != 0);
      rdy_h[k] = l0_ready;
      if (done_cyc.size() > 0 && k >= done_cyc[0] + 3) break;
    end
    start = 1'b0;

    // Model: reads issue on the first ln cycles (from cycle 1) with ready high.
    kk = 1;
    while (iss_c.size() < ln && kk < LIM) begin
      if (rdy_h[kk]) iss_c.push_back(kk);
      kk++;
    end
    if (ln == 0) exp_done = 1;
    else exp_done = iss_c[ln-1] + 2 + ln + ROW + 1;

    chk({tag, "_cen_count"}, cen_cyc.size(), ln);
    for (int i = 0; i < ln && i < cen_cyc.size(); i++) begin
      chk({tag, "_addr"}, addr_tr[i], (base + i) % (1 << ADDR_W));
      chk({tag, "_cen_cycle"}, cen_cyc[i], iss_c[i] + 1);
    end
    chk({tag, "_wr_count"}, wr_cyc.size(), ln);
    for (int i = 0; i < ln && i < wr_cyc.size(); i++)
      chk({tag, "_wr_cycle"}, wr_cyc[i], iss_c[i] + 2);
    chk({tag, "_rd_count"}, rd_cyc.size(), ln);
    for (int i = 0; i < ln && i < rd_cyc.size(); i++)
      chk({tag, "_rd_cycle"}, rd_cyc[i], iss_c[ln-1] + 3 + i);
    chk({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk({tag, "_done_cycle"}, done_cyc[0], exp_done);
      if (exp_tab >= 0) chk({tag, "_done_latency"}, done_cyc[0], exp_tab);
    end
    for (int k = 1; k <= last_k; k++)
      if (busy_h[k] != (k <= exp_done)) busy_bad++;
    chk({tag, "_busy_profile"}, busy_bad, 0);
    chk({tag, "_wen_low"}, wen_bad, 0);
    chk({tag, "_ovf"}, ovf_seen, 0);
  endtask

  initial begin
    int to;
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    l0_ready = 1'b1; l0_full = 1'b0;

    tbl[0] = '{base: 'h010, ln: 4,  mode: 0, s0: 0, sl: 0, spur: 0, exp_done: 19};
    tbl[1] = '{base: 'h7F0, ln: 64, mode: 0, s0: 0, sl: 0, spur: 0, exp_done: 139};
    tbl[2] = '{base: 'h100, ln: 6,  mode: 1, s0: 3, sl: 3, spur: 0, exp_done: 26};
    tbl[3] = '{base: 'h055, ln: 0,  mode: 0, s0: 0, sl: 0, spur: 0, exp_done: 1};
    tbl[4] = '{base: 'h200, ln: 5,  mode: 0, s0: 0, sl: 0, spur: 4, exp_done: 21};
    tbl[5] = '{base: 'h3FF, ln: 1,  mode: 0, s0: 0, sl: 0, spur: 0, exp_done: 13};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    foreach (tbl[i])
      run_tile(tbl[i].base, tbl[i].ln, tbl[i].mode, tbl[i].s0, tbl[i].sl,
               tbl[i].spur, tbl[i].exp_done, $sformatf("tbl%0d", i));

    // Reset during DRAIN aborts at once, without a done pulse.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h020; len = 7'd4;
    @(posedge clk); #1;
    start = 1'b0;
    to = 0;
    while (!l0_rd && to < 50) begin @(posedge clk); #1; to++; end
    chk("drain_reached", int'(l0_rd), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    to = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done || busy) to++;
    end
    chk("no_done_after_abort", to, 0);
    run_tile('h0A0, 2, 0, 0, 0, 0, 15, "post_reset");

    // Random tiles with random back-pressure.
    for (int t = 0; t < 8; t++)
      run_tile(int'($urandom_range(0, (1 << ADDR_W) - 1)),
               int'($urandom_range(1, DEPTH)), 2, 0, 0, 0, -1,
               $sformatf("rand%0d", t));

    // Writing while L0 claims full sets the sticky error; reset clears it.
    l0_full = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h000; len = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    to = 0;
    while (!done && to < 100) begin @(posedge clk); #1; to++; end
    chk("ovf_tile_done", int'(done), 1);
    l0_full = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_sticky", int'(ovf_err), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ovf_cleared", int'(ovf_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l0_seq_ctrl.md
Name: l0_seq_ctrl

Overview:
- Sequencer for the 8-row L0 input buffer.
- On each start command it:
  - reads a tile of `len` activation vectors from the activation SRAM,
  - writes them into L0,
  - then holds the L0 read request for exactly `len` cycles, so every row FIFO pops `len` entries into the array.
- Sits between the top-level core controller and the L0/SRAM pair. It replaces hand-driven wr/rd/cen sequences in the testbench.

Parameters:
- ROW, 8, number of L0 row FIFOs; equals the length of the L0 read-enable ramp.
- ADDR_W, 11, SRAM address width.
- LEN_W, 7, width of tile length; must hold DEPTH.
- DEPTH, 64, L0 FIFO depth; maximum legal `len`.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; sampled only in IDLE
- base_addr  input  ADDR_W  first SRAM address of the tile; latched on start
- len  input  LEN_W  vectors in the tile, 0..DEPTH; latched on start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at tile completion
- sram_cen  output  1  SRAM chip enable, active low
- sram_wen  output  1  SRAM write enable, active low; tied high (read only)
- sram_addr  output  ADDR_W  SRAM read address
- l0_wr  output  1  L0 write strobe
- l0_rd  output  1  L0 read request, drives the L0 `rd` input
- l0_ready  input  1  L0 not-full indication
- l0_full  input  1  L0 full indication; used for error detection only
- ovf_err  output  1  sticky; set if l0_wr is asserted while l0_full is high

Behaviour:
- Reset: state=IDLE; all counters cleared; busy=0, done=0, sram_cen=1, sram_wen=1, sram_addr=0, l0_wr=0, l0_rd=0, ovf_err=0.
  - Reset mid-tile aborts immediately, no done pulse. L0 shares the same reset, so no drain is needed.
- Outputs: all registered.
- States: IDLE, FILL, WAITWR, DRAIN, FLUSH, DONE.
- IDLE:
  - start=1 and len>0: latch base_addr and len, clear iss_cnt/wr_cnt/rd_cnt, go to FILL.
  - start=1 and len=0: go straight to DONE.
  - start in any other state is ignored.
- FILL, read issue:
  - Each cycle with l0_ready=1 and iss_cnt<len: sram_cen=0, sram_addr=base+iss_cnt (modulo 2^ADDR_W, wraps silently), iss_cnt++.
  - If l0_ready=0: sram_cen=1, issue stalls, no skipped addresses.
  - When iss_cnt reaches len: go to WAITWR.
- Write path:
  - SRAM read latency is 1 cycle. A registered valid bit follows each issued read, so l0_wr=1 exactly one cycle after each cen-low cycle.
  - wr_cnt increments per l0_wr.
  - In-flight reads complete even if l0_ready falls.
  - Safety argument: len≤DEPTH and L0 is empty at start, so full cannot be reached. ovf_err flags any violation.
- WAITWR: wait until wr_cnt==len. This is the cycle after the last issue; go to DRAIN next cycle.
- DRAIN:
  - l0_rd=1 for exactly len consecutive cycles, counted by rd_cnt, with no gaps.
  - Then l0_rd=0 and go to FLUSH.
  - Row i's enable rises i+1 cycles after l0_rd first rises and falls i+1 cycles after l0_rd falls, so each row pops exactly len entries.
- FLUSH: hold l0_rd=0 for ROW cycles until the L0 ramp reaches all-zero, then go to DONE.
- DONE: done=1 for one cycle, busy=1; next cycle IDLE.
- Total latency from start to done, with l0_ready constantly high and len=N≥1: 2N+ROW+3 cycles.

Test Plan:
1. Reset, then start with base=0x010, len=4 -> sram_addr sequence 0x010..0x013 on 4 consecutive cen-low cycles; l0_wr lags each by 1 cycle; l0_rd high exactly 4 cycles; done pulses 2·4+8+3=19 cycles after start; L0 outputs the 4 vectors in order on all rows.
2. len=64, base=0x7F0 -> addresses wrap 0x7FF→0x000; 64 writes; l0_full never asserted; ovf_err stays 0; done occurs.
3. Force l0_ready=0 for 3 cycles mid-FILL -> cen high for those cycles; address sequence resumes without a gap or repeat; write count still equals len.
4. len=0 -> done one cycle after start; no cen, wr or rd activity.
5. Assert reset during DRAIN -> next cycle all outputs are at reset values, no done; a subsequent start with len=2 completes normally.
6. Pulse start while busy -> ignored; latched base/len unchanged; exactly one done pulse.
